text_terminal: RTL and testbench
================================

Name: text_terminal

Overview:
- Character-cell text buffer that sits directly upstream of the console glyph renderer.
- Accepts a byte stream through a valid/ready handshake and interprets it as terminal output, including cursor movement, line wrap and hardware scroll.
- Serves codepoint/attribute lookups indexed by the HDMI pixel counters cx/cy, so the console draws the stored text instead of a synthetic pattern.
- Single clock domain: clk_pixel.

Parameters:
COLUMNS, 80, characters per row (640 px / 8 px glyph width)
ROWS, 30, character rows (480 px / 16 px glyph height)
CLEAR_ATTRIBUTE, 8'h07, attribute written with space (0x20) whenever cells are cleared

Ports:
clk_pixel  input  1  pixel clock; all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
in_data  input  8  byte to interpret
in_attribute  input  8  attribute stored with a printable in_data
in_valid  input  1  in_data/in_attribute valid
in_ready  output  1  block can accept a byte this cycle
cx  input  10  current pixel x from hdmi
cy  input  10  current pixel y from hdmi
codepoint  output  8  character for console at the registered cx/cy
attribute  output  8  attribute for console at the registered cx/cy
cursor_col  output  7  current cursor column, 0..COLUMNS-1
cursor_row  output  5  current logical cursor row, 0..ROWS-1

Behaviour:
- Storage: ROWS*COLUMNS x 16-bit simple dual-port RAM, holding {attribute, codepoint}. One write port and one read port. Not reset.
- Physical row = (logical row + top_row) mod ROWS. Address = physical_row*COLUMNS + col.
- Async reset (reset_n low): cursor_col=0, cursor_row=0, top_row=0, state=CLEAR_ALL, clear counter=0, codepoint=8'h20, attribute=8'h00, in_ready=0.
- States:
  - CLEAR_ALL: write {CLEAR_ATTRIBUTE, 8'h20} to address 0..ROWS*COLUMNS-1, one per cycle. After the last write go to IDLE and set cursor to (0,0).
  - CLEAR_ROW: write the COLUMNS cells of one physical row, one per cycle, then go to IDLE.
  - IDLE: in_ready=1.
- in_ready is high only in IDLE; it is a registered state decode. A byte is accepted on a rising edge where in_valid && in_ready.
- Byte handling in IDLE:
  - 0x0A (LF): col=0, then advance row.
  - 0x0D (CR): col=0.
  - 0x08 (BS): if col>0 then col-1, with no erase; if col==0 there is no change.
  - 0x0C (FF): go to CLEAR_ALL and restart the counter. Cursor becomes (0,0) when the clear completes.
  - All other values are printable. On the accept edge, write {in_attribute, in_data} at the cursor, then col+1. If col reaches COLUMNS, set col=0 and advance row.
- Advance row:
  - If row<ROWS-1: row+1.
  - Otherwise row stays ROWS-1, top_row=(top_row+1) mod ROWS, and the block enters CLEAR_ROW on the new bottom physical row (the old top_row).
  - in_ready is low for exactly COLUMNS cycles, and goes high the cycle after the last clear write.
- Wrap and scroll in the same byte (printable at col COLUMNS-1, row ROWS-1) behaves exactly as an LF after the write.
- Read path, latency 1:
  - col_r = cx>>3, row_r = cy>>4.
  - If cx<COLUMNS*8 and cy<ROWS*16, codepoint/attribute at edge N+1 equal the RAM contents at the logical cell for cx/cy sampled at edge N.
  - Otherwise codepoint=8'h20 and attribute=8'h00.
- Read and write to the same address in the same cycle returns the old data. The new data is visible next access.
- Reset asserted mid-operation (any state) aborts immediately. The full clear restarts on deassert.

Test Plan:
1. Release reset -> in_ready=0 for exactly 2400 cycles, then 1. Full-frame scan returns 0x20/0x07 in every cell and 0x20/0x00 for cx>=640 or cy>=480.
2. Send 0x41 with attr 0x1E -> cursor (row 0, col 1). At cx=0..7, cy=0..15 the outputs are 0x41/0x1E one cycle after the cx/cy sample. cx=8 returns 0x20/0x07.
3. Send 81 bytes 0x30..0x80 -> byte 81 (0x80) is at row 1 col 0, and the cursor is (1,1).
4. Cursor at row 29 with 0x5A at row 1 col 0; send 0x0A -> in_ready low exactly 80 cycles. Logical row 0 col 0 reads 0x5A, row 29 is all 0x20/0x07, cursor is (29,0).
5. Backspace and carriage return:
   - At col 0, send 0x08 -> cursor unchanged.
   - At col 5, send 0x08 -> col 4, cell contents unchanged.
   - Send 0x0D -> col 0.
6. Form feed and reset:
   - Send 0x0C -> in_ready low 2400 cycles, cursor (0,0), screen blank.
   - Pulse reset_n low during CLEAR_ROW (cycle 40) -> cursor, outputs and in_ready reset asynchronously, then a 2400-cycle clear follows.

Source files
------------

// File: rtl/text_terminal.sv
`default_nettype none
// ============================================================================
// Module      : text_terminal
// Description : Character-cell text buffer feeding the console glyph renderer.
//               Interprets an incoming byte stream as terminal output (cursor
//               movement, line wrap, hardware scroll through a rotating top
//               row) and serves {attribute, codepoint} lookups for the HDMI
//               pixel counters with one cycle of latency.
// Ports       : clk_pixel    - pixel clock, all logic on rising edge
//               reset_n      - asynchronous active-low reset
//               in_data      - byte to interpret
//               in_attribute - attribute stored alongside a printable byte
//               in_valid     - in_data/in_attribute valid
//               in_ready     - byte can be accepted this cycle
//               cx, cy       - current pixel coordinates from the HDMI timing
//               codepoint    - character at the previously sampled cx/cy
//               attribute    - attribute at the previously sampled cx/cy
//               cursor_col   - cursor column, 0..COLUMNS-1
//               cursor_row   - logical cursor row, 0..ROWS-1
// Revision    : 1.0 - initial release
// ============================================================================
module text_terminal #(
    parameter int         COLUMNS         = 80,
    parameter int         ROWS            = 30,
    parameter logic [7:0] CLEAR_ATTRIBUTE = 8'h07
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic [7:0] in_attribute,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic [7:0] codepoint,
    output logic [7:0] attribute,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);

    localparam int                  c_CELLS     = ROWS * COLUMNS;
    localparam int                  c_ADDR_W    = $clog2(c_CELLS);
    localparam logic [c_ADDR_W-1:0] c_LAST_CELL = c_ADDR_W'(c_CELLS - 1);
    localparam logic [c_ADDR_W-1:0] c_ROW_LAST  = c_ADDR_W'(COLUMNS - 1);
    localparam logic [6:0]          c_LAST_COL  = 7'(COLUMNS - 1);
    localparam logic [4:0]          c_LAST_ROW  = 5'(ROWS - 1);
    localparam logic [9:0]          c_X_LIMIT   = 10'(COLUMNS * 8);
    localparam logic [9:0]          c_Y_LIMIT   = 10'(ROWS * 16);
    localparam logic [15:0]         c_BLANK     = {CLEAR_ATTRIBUTE, 8'h20};
    localparam logic [15:0]         c_OFFSCREEN = 16'h0020;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL = 2'd0,
        ST_CLEAR_ROW = 2'd1,
        ST_IDLE      = 2'd2
    } state_t;

    // Logical rows are rotated by r_top so a scroll costs one row clear
    // instead of a full-frame copy.
    function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
        logic [5:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= 6'(ROWS)) begin
            sum = sum - 6'(ROWS);
        end
        return sum[4:0];
    endfunction

    function automatic logic [c_ADDR_W-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
        return c_ADDR_W'(prow) * c_ADDR_W'(COLUMNS) + c_ADDR_W'(col);
    endfunction

    logic [15:0]         r_mem [0:c_CELLS-1];

    state_t              r_state;
    state_t              w_next_state;
    logic [c_ADDR_W-1:0] r_cnt;
    logic [c_ADDR_W-1:0] w_next_cnt;
    logic [4:0]          r_top;
    logic [4:0]          w_next_top;
    logic [4:0]          r_clr_row;
    logic [4:0]          w_next_clr_row;
    logic [6:0]          w_next_col;
    logic [4:0]          w_next_row;
    logic                w_advance;
    logic                w_accept;
    logic                w_we;
    logic [c_ADDR_W-1:0] w_waddr;
    logic [15:0]         w_wdata;

    logic                w_rd_in_range;
    logic [c_ADDR_W-1:0] w_rd_addr;
    logic                w_unused_bits;

    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state, write port and cursor update
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_top     = r_top;
        w_next_clr_row = r_clr_row;
        w_next_col     = cursor_col;
        w_next_row     = cursor_row;
        w_advance      = 1'b0;
        w_we           = 1'b0;
        w_waddr        = '0;
        w_wdata        = c_BLANK;

        case (r_state)
            ST_CLEAR_ALL: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
                if (r_cnt == c_LAST_CELL) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                    w_next_col   = 7'd0;
                    w_next_row   = 5'd0;
                end else begin
                    w_next_cnt = r_cnt + c_ADDR_W'(1);
                end
            end

            ST_CLEAR_ROW: begin
                w_we    = 1'b1;
                w_waddr = cell_addr(r_clr_row, r_cnt[6:0]);
                if (r_cnt == c_ROW_LAST) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + c_ADDR_W'(1);
                end
            end

            ST_IDLE: begin
                if (w_accept) begin
                    case (in_data)
                        8'h0A: begin
                            w_next_col = 7'd0;
                            w_advance  = 1'b1;
                        end
                        8'h0D: begin
                            w_next_col = 7'd0;
                        end
                        8'h08: begin
                            if (cursor_col != 7'd0) begin
                                w_next_col = cursor_col - 7'd1;
                            end
                        end
                        8'h0C: begin
                            w_next_state = ST_CLEAR_ALL;
                            w_next_cnt   = '0;
                        end
                        default: begin
                            w_we    = 1'b1;
                            w_waddr = cell_addr(phys_row(cursor_row, r_top), cursor_col);
                            w_wdata = {in_attribute, in_data};
                            if (cursor_col == c_LAST_COL) begin
                                w_next_col = 7'd0;
                                w_advance  = 1'b1;
                            end else begin
                                w_next_col = cursor_col + 7'd1;
                            end
                        end
                    endcase

                    // At the bottom the cursor row stays put; the old top
                    // physical row becomes the new (cleared) bottom row.
                    if (w_advance) begin
                        if (cursor_row != c_LAST_ROW) begin
                            w_next_row = cursor_row + 5'd1;
                        end else begin
                            w_next_top     = (r_top == c_LAST_ROW) ? 5'd0 : r_top + 5'd1;
                            w_next_clr_row = r_top;
                            w_next_state   = ST_CLEAR_ROW;
                            w_next_cnt     = '0;
                        end
                    end
                end
            end

            default: begin
                w_next_state = ST_CLEAR_ALL;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_CLEAR_ALL;
            r_cnt      <= '0;
            r_top      <= '0;
            r_clr_row  <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            in_ready   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_top      <= w_next_top;
            r_clr_row  <= w_next_clr_row;
            cursor_col <= w_next_col;
            cursor_row <= w_next_row;
            in_ready   <= (w_next_state == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Cell storage: one write port, one registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pixel) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Only the cell-index bits of cx/cy matter; cy[9] is zero whenever
    // the read is in range.
    assign w_rd_in_range = (cx < c_X_LIMIT) && (cy < c_Y_LIMIT);
    assign w_rd_addr     = cell_addr(phys_row(cy[8:4], r_top), cx[9:3]);
    assign w_unused_bits = ^{cx[2:0], cy[3:0], cy[9]};

    // Same-cycle read/write to one address returns the old contents.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            {attribute, codepoint} <= c_OFFSCREEN;
        end else if (w_rd_in_range) begin
            {attribute, codepoint} <= r_mem[w_rd_addr];
        end else begin
            {attribute, codepoint} <= c_OFFSCREEN;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_terminal.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_terminal
// Description : Self-checking bench for text_terminal. Read probes push the
//               expected cell into a queue; a monitor pops and compares one
//               cycle later. Status outputs are checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_terminal;

    localparam int c_COLS = 80;
    localparam int c_ROWS = 30;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [7:0] in_data;
    logic [7:0] in_attribute;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [7:0] codepoint;
    logic [7:0] attribute;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    always #5 clk_pixel = ~clk_pixel;

    text_terminal #(
        .COLUMNS         (80),
        .ROWS            (30),
        .CLEAR_ATTRIBUTE (8'h07)
    ) dut (
        .clk_pixel    (clk_pixel),
        .reset_n      (reset_n),
        .in_data      (in_data),
        .in_attribute (in_attribute),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cx           (cx),
        .cy           (cy),
        .codepoint    (codepoint),
        .attribute    (attribute),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    logic        probe_on = 1'b0;
    logic        probe_q  = 1'b0;
    logic [15:0] scr [c_ROWS][c_COLS];

    // Monitor: a probe driven before edge N is answered after edge N.
    always @(posedge clk_pixel) probe_q <= probe_on;

    always @(negedge clk_pixel) begin
        if (probe_q) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: read output with no expected entry");
            end else begin
                mon_e = sb_q.pop_front();
                if ({attribute, codepoint} !== mon_e.exp) begin
                    bad++;
                    $display("FAIL read cx=%0d cy=%0d: got attr=%h cp=%h, expected attr=%h cp=%h",
                             mon_e.x, mon_e.y, attribute, codepoint, mon_e.exp[15:8], mon_e.exp[7:0]);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < c_ROWS; r++)
            for (int c = 0; c < c_COLS; c++)
                scr[r][c] = 16'h0720;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < c_ROWS - 1; r++)
            for (int c = 0; c < c_COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < c_COLS; c++)
            scr[c_ROWS-1][c] = 16'h0720;
    endtask

    // All tasks start and end one time unit after a rising edge.
    task automatic probe(input int x, input int y, input logic [15:0] e);
        sb_t s;
        cx       = 10'(x);
        cy       = 10'(y);
        probe_on = 1'b1;
        s.x      = 10'(x);
        s.y      = 10'(y);
        s.exp    = e;
        sb_q.push_back(s);
        @(posedge clk_pixel); #1;
    endtask

    task automatic probe_stop();
        probe_on = 1'b0;
    endtask

    task automatic scan_all();
        for (int r = 0; r < c_ROWS; r++)
            for (int c = 0; c < c_COLS; c++)
                probe(c*8 + (r % 8), r*16 + (c % 16), scr[r][c]);
        probe(640, 0, 16'h0020);
        probe(0, 480, 16'h0020);
        probe(1023, 1023, 16'h0020);
        probe(700, 100, 16'h0020);
        probe(639, 479, scr[29][79]);
        probe_stop();
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            @(posedge clk_pixel); #1;
            n++;
        end
    endtask

    task automatic wait_ready(output bit ok);
        int guard;
        guard = 0;
        while (!in_ready && guard < 5000) begin
            @(posedge clk_pixel); #1;
            guard++;
        end
        ok = in_ready;
    endtask

    task automatic send_nowait(input logic [7:0] d, input logic [7:0] a);
        bit ok;
        in_data      = d;
        in_attribute = a;
        in_valid     = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end else begin
            @(posedge clk_pixel); #1;
        end
        in_valid = 1'b0;
    endtask

    // Returns the number of cycles in_ready stays low after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] a, output int low);
        bit ok;
        in_data      = d;
        in_attribute = a;
        in_valid     = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %h never accepted", d);
            in_valid = 1'b0;
            low      = -1;
        end else begin
            @(posedge clk_pixel); #1;
            in_valid = 1'b0;
            count_low(low);
        end
    endtask

    initial begin
        int n;
        in_data      = 8'h00;
        in_attribute = 8'h00;
        in_valid     = 1'b0;
        cx           = 10'd0;
        cy           = 10'd0;
        reset_n      = 1'b0;

        // ---- 1: reset state, initial clear, full scan ----
        repeat (3) @(posedge clk_pixel); #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cursor_col", int'(cursor_col), 0);
        check("rst_cursor_row", int'(cursor_row), 0);
        check("rst_codepoint", int'(codepoint), 32'h20);
        check("rst_attribute", int'(attribute), 32'h00);
        reset_n = 1'b1;
        count_low(n);
        check("init_clear_cycles", n, 2400);
        model_clear();
        scan_all();

        // ---- 2: single printable ----
        send_byte(8'h41, 8'h1E, n);
        check("t2_low", n, 0);
        check("t2_col", int'(cursor_col), 1);
        check("t2_row", int'(cursor_row), 0);
        scr[0][0] = 16'h1E41;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++)
                probe(x, y, 16'h1E41);
        probe(8, 0, 16'h0720);
        probe(15, 15, 16'h0720);
        probe_stop();

        // ---- 3: 81 bytes wrap onto row 1 ----
        send_byte(8'h0D, 8'h00, n);
        check("t3_cr_col", int'(cursor_col), 0);
        for (int i = 0; i < 81; i++) begin
            send_byte(8'(8'h30 + i), 8'h2F, n);
            check("t3_low", n, 0);
            scr[i / 80][i % 80] = {8'h2F, 8'(8'h30 + i)};
        end
        check("t3_col", int'(cursor_col), 1);
        check("t3_row", int'(cursor_row), 1);
        probe(0, 0, 16'h2F30);
        probe(79*8, 0, 16'h2F7F);
        probe(0, 16, 16'h2F80);
        probe(8, 16, 16'h0720);
        probe_stop();

        // ---- 4: LF at bottom row scrolls ----
        send_byte(8'h0D, 8'h00, n);
        send_byte(8'h5A, 8'h4E, n);
        scr[1][0] = 16'h4E5A;
        check("t4_col", int'(cursor_col), 1);
        check("t4_row", int'(cursor_row), 1);
        for (int i = 0; i < 28; i++) begin
            send_byte(8'h0A, 8'h00, n);
            check("t4_lf_low", n, 0);
        end
        check("t4_bottom_row", int'(cursor_row), 29);
        check("t4_bottom_col", int'(cursor_col), 0);
        send_byte(8'h0A, 8'h00, n);
        check("t4_scroll_low", n, 80);
        model_scroll();
        check("t4_scroll_row", int'(cursor_row), 29);
        check("t4_scroll_col", int'(cursor_col), 0);
        probe(0, 0, 16'h4E5A);
        probe_stop();
        scan_all();

        // ---- wrap and scroll in one byte ----
        for (int i = 0; i < 79; i++) begin
            send_byte(8'(8'h61 + (i % 26)), 8'h17, n);
            scr[29][i] = {8'h17, 8'(8'h61 + (i % 26))};
        end
        check("wrap_col_before", int'(cursor_col), 79);
        send_byte(8'h42, 8'h71, n);
        check("wrap_scroll_low", n, 80);
        scr[29][79] = 16'h7142;
        model_scroll();
        check("wrap_row", int'(cursor_row), 29);
        check("wrap_col", int'(cursor_col), 0);
        probe(79*8, 28*16, 16'h7142);
        probe(0, 28*16, 16'h1761);
        probe_stop();
        scan_all();

        // ---- 5: backspace and carriage return ----
        send_byte(8'h08, 8'h00, n);
        check("bs0_col", int'(cursor_col), 0);
        check("bs0_row", int'(cursor_row), 29);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h61 + i), 8'h0A, n);
            scr[29][i] = {8'h0A, 8'(8'h61 + i)};
        end
        check("bs_pre_col", int'(cursor_col), 5);
        send_byte(8'h08, 8'h00, n);
        check("bs_col", int'(cursor_col), 4);
        check("bs_row", int'(cursor_row), 29);
        probe(4*8, 29*16, 16'h0A65);
        probe(3*8, 29*16, 16'h0A64);
        probe(5*8, 29*16, 16'h0720);
        probe_stop();
        send_byte(8'h0D, 8'h00, n);
        check("cr_col", int'(cursor_col), 0);

        // ---- 6: form feed ----
        send_byte(8'h0C, 8'h00, n);
        check("ff_low", n, 2400);
        check("ff_col", int'(cursor_col), 0);
        check("ff_row", int'(cursor_row), 0);
        model_clear();
        scan_all();

        // ---- reset during row clear ----
        cx = 10'd0;
        cy = 10'd0;
        for (int i = 0; i < 29; i++) send_byte(8'h0A, 8'h00, n);
        check("mid_pre_row", int'(cursor_row), 29);
        send_nowait(8'h0A, 8'h00);
        repeat (40) @(posedge clk_pixel);
        #3;
        check("mid_ready_low", int'(in_ready), 0);
        check("mid_pre_attr", int'(attribute), 32'h07);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(in_ready), 0);
        check("mid_rst_row", int'(cursor_row), 0);
        check("mid_rst_col", int'(cursor_col), 0);
        check("mid_rst_cp", int'(codepoint), 32'h20);
        check("mid_rst_attr", int'(attribute), 32'h00);
        repeat (3) @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;
        count_low(n);
        check("mid_clear_cycles", n, 2400);
        check("mid_final_row", int'(cursor_row), 0);
        check("mid_final_col", int'(cursor_col), 0);
        model_clear();
        scan_all();

        repeat (2) @(posedge clk_pixel);
        #1;
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
